// File: rtl/id_ex_hazard_ctrl_if.sv
// Decode/execute hazard bus: pipeline-side fields in, stall/flush controls out.
// The pipeline drives through the master modport; the hazard controller uses slave.
interface id_ex_hazard_ctrl_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        ex_memread;
   logic        ex_regwrite;
   logic [4:0]  ex_rt;
   logic        branch_taken;
   logic        pc_write;
   logic        ifid_write;
   logic        ifid_flush;
   logic        idex_bubble;
   logic        stall_active;
   logic [31:0] stall_cycles;
   logic [31:0] flush_events;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_memread, ex_regwrite, ex_rt, branch_taken,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, stall_active,
      input  stall_cycles, flush_events
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_memread, ex_regwrite, ex_rt, branch_taken,
      output pc_write, ifid_write, ifid_flush, idex_bubble, stall_active,
      output stall_cycles, flush_events
   );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// Load-use stall and taken-branch squash controller beside the ID/EX register.
// A load-use hazard freezes PC and IF/ID for exactly LOAD_LAT cycles while
// bubbles are injected into ID/EX; a taken branch flushes IF/ID and ID/EX.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush perf counters;
// without it stall_cycles and flush_events are tied to zero.
// Legal parameters: 1 <= LOAD_LAT <= 2**CNT_W-1.
module id_ex_hazard_ctrl #(
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 4
) (
   input logic                clk,
   input logic                rst_n,
   id_ex_hazard_ctrl_if.slave bus
);

   typedef enum logic [0:0] {StRun, StStall} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              hz;
   logic              pc_write_c;
   logic              ifid_write_c;
   logic              ifid_flush_c;
   logic              idex_bubble_c;
   logic              stall_active_c;

   // Load-use hazard: in-flight load targets a source of the decode instruction.
   always_comb begin
      hz = bus.ex_memread & bus.ex_regwrite & (bus.ex_rt != 5'd0) &
           ((bus.ex_rt == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));
   end

   // Next-state and combinational outputs; reset forces a safe frozen/flushed view.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      pc_write_c     = 1'b1;
      ifid_write_c   = 1'b1;
      ifid_flush_c   = 1'b0;
      idex_bubble_c  = 1'b0;
      stall_active_c = 1'b0;
      if (!rst_n) begin
         state_d       = StRun;
         cnt_d         = '0;
         pc_write_c    = 1'b0;
         ifid_write_c  = 1'b0;
         ifid_flush_c  = 1'b1;
         idex_bubble_c = 1'b1;
      end else begin
         unique case (state_q)
            StRun: begin
               if (bus.branch_taken) begin
                  ifid_flush_c  = 1'b1;
                  idex_bubble_c = 1'b1;
               end else if (hz) begin
                  pc_write_c    = 1'b0;
                  ifid_write_c  = 1'b0;
                  idex_bubble_c = 1'b1;
                  // Single-cycle latency needs no state: the bubble clears hz next cycle.
                  if (LOAD_LAT > 1) begin
                     state_d = StStall;
                     cnt_d   = CNT_W'(LOAD_LAT - 1);
                  end
               end
            end
            StStall: begin
               stall_active_c = 1'b1;
               if (bus.branch_taken) begin
                  // Should not happen with a bubble in EX; squash and recover anyway.
                  ifid_flush_c  = 1'b1;
                  idex_bubble_c = 1'b1;
                  state_d       = StRun;
                  cnt_d         = '0;
               end else begin
                  pc_write_c    = 1'b0;
                  ifid_write_c  = 1'b0;
                  idex_bubble_c = 1'b1;
                  if (cnt_q == CNT_W'(1)) begin
                     state_d = StRun;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
            end
            default: begin
               state_d = StRun;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State and stall counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.pc_write     = pc_write_c;
   assign bus.ifid_write   = ifid_write_c;
   assign bus.ifid_flush   = ifid_flush_c;
   assign bus.idex_bubble  = idex_bubble_c;
   assign bus.stall_active = stall_active_c;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] flush_events_q;

   // Saturating perf counters for frozen-PC cycles and IF/ID flushes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         if (!pc_write_c && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if (ifid_flush_c && (flush_events_q != 32'hFFFF_FFFF)) begin
            flush_events_q <= flush_events_q + 32'd1;
         end
      end
   end

   assign bus.stall_cycles = stall_cycles_q;
   assign bus.flush_events = flush_events_q;
`else
   assign bus.stall_cycles = 32'd0;
   assign bus.flush_events = 32'd0;
`endif

endmodule
